// File: rtl/fan_pkg.sv
// Shared types and helpers for the fan controller core.
// The soft-start ramp is selected by the FAN_SOFT_START_EN macro in fan_ctrl_core.
package fan_pkg;

  // Operating state of the fan: OFF only while the speed level is zero.
  typedef enum logic [1:0] {
    FAN_OFF     = 2'd0,
    FAN_RUN     = 2'd1,
    FAN_BLOCKED = 2'd2
  } fan_state_e;

  // Board defaults: 100 MHz clock gives a 1 s tick, one preset step is one hour.
  localparam int DEF_TICK_DIV     = 100_000_000;
  localparam int DEF_TIMER_STEP_S = 3600;

  // Duty for a level, spread evenly from 0 to full scale and truncated.
  // 64-bit arithmetic keeps level*(2^pwm_w-1) from overflowing.
  function automatic longint level_to_duty(input int level, input int levels, input int pwm_w);
    longint full_scale;
    full_scale = (longint'(1) << pwm_w) - 64'sd1;
    return (full_scale * longint'(level)) / longint'(levels - 1);
  endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Free-running PWM generator: output is high while the counter is below duty.
// A duty of zero therefore yields a constant low output.
module fan_pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [PWM_W-1:0] i_duty,
  output logic             o_pwm
);

  logic [PWM_W-1:0] r_cnt;
  logic             r_pwm;

  // Counter wraps naturally at 2^PWM_W; compare result is registered to keep the pin glitch-free.
  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
    if (reset_p) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_pwm <= (r_cnt < i_duty);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/fan_ctrl_core.sv
// Fan controller core: speed level, countdown off-timer, distance safety stop
// with hysteresis, and PWM drive. Define FAN_SOFT_START_EN to ramp duty up
// gradually instead of jumping to the target.
module fan_ctrl_core
  import fan_pkg::*;
#(
  parameter int PWM_W        = 8,
  parameter int LEVELS       = 4,
  parameter int DIST_W       = 12,
  parameter int STOP_CM      = 10,
  parameter int RESUME_CM    = 15,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int TIMER_STEP_S = DEF_TIMER_STEP_S,
  parameter int TIMER_STEPS  = 3,
  parameter int RAMP_DIV     = 50_000
) (
  input  logic                             clk,
  input  logic                             reset_p,
  input  logic                             speed_btn,
  input  logic                             timer_btn,
  input  logic                             dist_valid,
  input  logic [DIST_W-1:0]                distance,
  output logic                             motor_pwm_o,
  output logic [$clog2(LEVELS)-1:0]        level_o,
  output logic [LEVELS-2:0]                level_led,
  output logic [$clog2(TIMER_STEPS+1)-1:0] timer_step_o,
  output logic [31:0]                      remain_s,
  output logic                             blocked_o
);

  localparam int LW = $clog2(LEVELS);
  localparam int SW = $clog2(TIMER_STEPS + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Reject configurations the control logic cannot honour.
  if (LEVELS < 2) begin : g_chk_levels
    $error("fan_ctrl_core: LEVELS must be at least 2");
  end
  if (RESUME_CM <= STOP_CM) begin : g_chk_hyst
    $error("fan_ctrl_core: RESUME_CM must exceed STOP_CM");
  end
  if (RAMP_DIV < 1 || TICK_DIV < 1) begin : g_chk_div
    $error("fan_ctrl_core: dividers must be at least 1");
  end

  fan_state_e       r_state, w_state_nxt;
  logic [LW-1:0]    r_level, w_level_nxt;
  logic [SW-1:0]    r_step, w_step_nxt;
  logic [31:0]      r_remain, w_remain_nxt;
  logic [TW-1:0]    r_tick, w_tick_nxt;
  logic             w_expire;
  logic [PWM_W-1:0] r_duty, w_target, w_goal;
  logic [LEVELS-2:0] w_led;

  // Constant per-level duty table, evaluated at elaboration.
  logic [PWM_W-1:0] w_duty_tbl [LEVELS];
  for (genvar g = 0; g < LEVELS; g++) begin : g_duty
    assign w_duty_tbl[g] = PWM_W'(level_to_duty(g, LEVELS, PWM_W));
  end

  // Timer: count down while the fan is on with a preset armed; a button press reloads.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_step_nxt   = r_step;
    w_remain_nxt = r_remain;
    w_tick_nxt   = r_tick;
    w_expire     = 1'b0;
    if ((r_state != FAN_OFF) && (r_step != '0)) begin
      if (r_tick == TW'(TICK_DIV - 1)) begin
        w_tick_nxt   = '0;
        w_remain_nxt = r_remain - 32'd1;
        if (r_remain == 32'd1) begin
          w_expire   = 1'b1;
          w_step_nxt = '0;
        end
      end else begin
        w_tick_nxt = r_tick + 1'b1;
      end
    end
    // A preset press wins over the countdown, including on the expiry cycle.
    if (timer_btn) begin
      w_step_nxt   = (r_step == SW'(TIMER_STEPS)) ? '0 : r_step + 1'b1;
      w_remain_nxt = 32'(w_step_nxt) * 32'(TIMER_STEP_S);
      w_tick_nxt   = '0;
    end
  end

  // Level: expiry forces off, otherwise the speed button steps and wraps.
  always_comb begin
    w_level_nxt = r_level;
    if (w_expire) begin
      w_level_nxt = '0;
    end else if (speed_btn) begin
      w_level_nxt = (r_level == LW'(LEVELS - 1)) ? '0 : r_level + 1'b1;
    end
  end

  // Next state follows the upcoming level so state and level change on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FAN_OFF: begin
        if (w_level_nxt != '0) w_state_nxt = FAN_RUN;
      end
      FAN_RUN: begin
        if (w_level_nxt == '0)
          w_state_nxt = FAN_OFF;
        else if (dist_valid && (distance < DIST_W'(STOP_CM)))
          w_state_nxt = FAN_BLOCKED;
      end
      FAN_BLOCKED: begin
        if (w_level_nxt == '0)
          w_state_nxt = FAN_OFF;
        else if (dist_valid && (distance >= DIST_W'(RESUME_CM)))
          w_state_nxt = FAN_RUN;
      end
      default: w_state_nxt = FAN_OFF;
    endcase
  end

  // Control registers: state, level and timer.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_state  <= FAN_OFF;
      r_level  <= '0;
      r_step   <= '0;
      r_remain <= '0;
      r_tick   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_level  <= w_level_nxt;
      r_step   <= w_step_nxt;
      r_remain <= w_remain_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  assign w_target = w_duty_tbl[r_level];
  assign w_goal   = (r_state == FAN_RUN) ? w_target : '0;

`ifdef FAN_SOFT_START_EN
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  logic [RW-1:0] r_ramp;

  // Soft start: climb one duty step per RAMP_DIV clocks; drops take effect at once.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_duty <= '0;
      r_ramp <= '0;
    end else if (w_goal <= r_duty) begin
      r_duty <= w_goal;
      r_ramp <= '0;
    end else if (r_ramp == RW'(RAMP_DIV - 1)) begin
      r_duty <= r_duty + 1'b1;
      r_ramp <= '0;
    end else begin
      r_ramp <= r_ramp + 1'b1;
    end
  end
`else
  // Duty follows the goal one cycle after any level or state change.
  always_ff @(posedge clk) begin
    if (reset_p) r_duty <= '0;
    else         r_duty <= w_goal;
  end
`endif

  fan_pwm_gen #(.PWM_W(PWM_W)) u_pwm (
    .clk     (clk),
    .reset_p (reset_p),
    .i_duty  (r_duty),
    .o_pwm   (motor_pwm_o)
  );

  // One-hot level indicator: bit k-1 lit for level k, dark when off.
  always_comb begin
    w_led = '0;
    for (int k = 1; k < LEVELS; k++) begin
      if (r_level == LW'(k)) w_led[k-1] = 1'b1;
    end
  end

  assign level_o      = r_level;
  assign level_led    = w_led;
  assign timer_step_o = r_step;
  assign remain_s     = r_remain;
  assign blocked_o    = (r_state == FAN_BLOCKED);

endmodule

// File: tb/tb_fan_ctrl_core.sv
// Self-checking bench for fan_ctrl_core with a behavioural reference model.
// Honours FAN_SOFT_START_EN when the design is built with it.
module tb_fan_ctrl_core;

  localparam int PWM_W = 8, LEVELS = 4, DIST_W = 12, STOP = 10, RESUME = 15;
  localparam int TICK = 10, STEP_S = 3, STEPS = 3, RAMP = 4;
  localparam int FULL = (1 << PWM_W) - 1;

  logic clk = 1'b0;
  logic reset_p, speed_btn, timer_btn, dist_valid;
  logic [DIST_W-1:0] distance;
  logic        motor_pwm_o;
  logic [1:0]  level_o;
  logic [2:0]  level_led;
  logic [1:0]  timer_step_o;
  logic [31:0] remain_s;
  logic        blocked_o;

  fan_ctrl_core #(
    .PWM_W(PWM_W), .LEVELS(LEVELS), .DIST_W(DIST_W), .STOP_CM(STOP), .RESUME_CM(RESUME),
    .TICK_DIV(TICK), .TIMER_STEP_S(STEP_S), .TIMER_STEPS(STEPS), .RAMP_DIV(RAMP)
  ) dut (
    .clk(clk), .reset_p(reset_p), .speed_btn(speed_btn), .timer_btn(timer_btn),
    .dist_valid(dist_valid), .distance(distance), .motor_pwm_o(motor_pwm_o),
    .level_o(level_o), .level_led(level_led), .timer_step_o(timer_step_o),
    .remain_s(remain_s), .blocked_o(blocked_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: the fan as seen from its pins, advanced once per clock.
  int m_level = 0, m_step = 0, m_remain = 0, m_sec = 0, m_duty = 0, m_cnt = 0, m_ramp = 0;
  bit m_blocked = 0, m_pwm = 0;
  int n_level, n_step, n_remain, n_sec, n_duty, n_cnt, n_ramp, goal;
  bit n_blocked, n_pwm, expire, fan_on;

  function automatic int target_duty(input int lv);
    return lv * FULL / (LEVELS - 1);
  endfunction

  always @(posedge clk) begin
    if (reset_p) begin
      m_level = 0; m_step = 0; m_remain = 0; m_sec = 0; m_duty = 0;
      m_cnt = 0; m_ramp = 0; m_blocked = 0; m_pwm = 0;
    end else begin
      fan_on = (m_level != 0);
      // PWM pin reflects the duty in force before this edge.
      n_pwm = (m_cnt < m_duty);
      n_cnt = (m_cnt + 1) % (FULL + 1);
      goal  = (fan_on && !m_blocked) ? target_duty(m_level) : 0;
      n_ramp = 0;
`ifdef FAN_SOFT_START_EN
      if (goal <= m_duty) n_duty = goal;
      else if (m_ramp == RAMP - 1) n_duty = m_duty + 1;
      else begin n_duty = m_duty; n_ramp = m_ramp + 1; end
`else
      n_duty = goal;
`endif
      // One second elapses every TICK clocks while the fan is on and a preset is armed.
      expire = 0; n_sec = m_sec; n_remain = m_remain; n_step = m_step;
      if (fan_on && m_step != 0) begin
        if (m_sec == TICK - 1) begin
          n_sec = 0;
          n_remain = m_remain - 1;
          if (n_remain == 0) begin expire = 1; n_step = 0; end
        end else n_sec = m_sec + 1;
      end
      if (timer_btn) begin
        n_step = (m_step + 1) % (STEPS + 1);
        n_remain = n_step * STEP_S;
        n_sec = 0;
      end
      if (expire) n_level = 0;
      else if (speed_btn) n_level = (m_level + 1) % LEVELS;
      else n_level = m_level;
      // Safety stop with hysteresis; only meaningful while on and staying on.
      n_blocked = m_blocked;
      if (n_level == 0 || !fan_on) n_blocked = 0;
      else if (dist_valid) begin
        if (m_blocked && distance >= RESUME) n_blocked = 0;
        if (!m_blocked && distance < STOP) n_blocked = 1;
      end
      m_level = n_level; m_step = n_step; m_remain = n_remain; m_sec = n_sec;
      m_duty = n_duty; m_cnt = n_cnt; m_ramp = n_ramp; m_blocked = n_blocked; m_pwm = n_pwm;
    end
  end

  // Continuous comparison of every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("level", level_o, m_level);
      check("led", level_led, (m_level == 0) ? 0 : (1 << (m_level - 1)));
      check("step", timer_step_o, m_step);
      check("remain", remain_s, m_remain);
      check("blocked", blocked_o, m_blocked);
      check("pwm", motor_pwm_o, m_pwm);
    end
  end

  task automatic drive(input bit sp, input bit tm, input bit dv, input int d);
    speed_btn = sp; timer_btn = tm; dist_valid = dv; distance = DIST_W'(d);
    @(negedge clk);
    speed_btn = 0; timer_btn = 0; dist_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_p = 1;
    idle(2);
    reset_p = 0;
  endtask

  task automatic count_high(output int h);
    h = 0;
    repeat (FULL + 1) begin
      @(negedge clk);
      h += int'(motor_pwm_o);
    end
  endtask

  // Park on the negedge just before the edge at which the timer expires.
  task automatic wait_pre_expiry(input string tag);
    int cyc;
    cyc = 0;
    while (!(m_level != 0 && m_remain == 1 && m_sec == TICK - 1) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, cyc < 200, 1);
  endtask

  int h, cyc;
  int exp_high [4] = '{85, 170, 255, 0};

  initial begin
    reset_p = 1; speed_btn = 0; timer_btn = 0; dist_valid = 0; distance = '0;
    idle(2);
    reset_p = 0;
    chk_en = 1;
    check("rst_level", level_o, 0);
    check("rst_remain", remain_s, 0);
    check("rst_pwm", motor_pwm_o, 0);

    // Level stepping, LED pattern and PWM duty per level.
    for (int k = 1; k <= 4; k++) begin
      drive(1, 0, 0, 0);
      check("t1_level", level_o, k % 4);
      check("t1_led", level_led, (k == 4) ? 0 : (1 << (k - 1)));
`ifndef FAN_SOFT_START_EN
      idle(3);
      count_high(h);
      check("t1_high", h, exp_high[k-1]);
`endif
    end

    // Safety stop with hysteresis.
    do_reset();
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    idle(3);
    drive(0, 0, 1, 8);
    idle(3);
    check("t2_block", blocked_o, 1);
    count_high(h);
    check("t2_high_blocked", h, 0);
    drive(0, 0, 1, 12);
    idle(2);
    check("t2_hold", blocked_o, 1);
    drive(0, 0, 1, 20);
    idle(3);
    check("t2_resume", blocked_o, 0);
`ifndef FAN_SOFT_START_EN
    count_high(h);
    check("t2_high_resume", h, 170);
`endif

    // Timer expiry after 3 s of 10 clocks each, then paused while off.
    do_reset();
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    check("t3_remain", remain_s, 3);
    cyc = 0;
    while (level_o != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_expire_cycles", cyc, 30);
    check("t3_remain0", remain_s, 0);
    check("t3_step0", timer_step_o, 0);
    drive(0, 1, 0, 0);
    idle(40);
    check("t3_frozen", remain_s, 3);

    // Simultaneous events around expiry.
    do_reset();
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    wait_pre_expiry("t4_reach1");
    drive(1, 0, 0, 0);
    check("t4_expiry_beats_speed", level_o, 0);
    check("t4_step_cleared", timer_step_o, 0);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    wait_pre_expiry("t4_reach2");
    drive(1, 1, 0, 0);
    check("t4_expiry_level", level_o, 0);
    check("t4_expiry_preset", timer_step_o, 2);
    check("t4_expiry_remain", remain_s, 6);
    drive(1, 1, 0, 0);
    check("t4_both_level", level_o, 1);
    check("t4_both_step", timer_step_o, 3);
    check("t4_both_remain", remain_s, 9);

`ifdef FAN_SOFT_START_EN
    // Full ramp from 0 to 255 takes 1020 clocks.
    do_reset();
    drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    idle(1030);
    count_high(h);
    check("t5_ramped", h, 255);
`endif

    // Reset in RUN and in BLOCKED with the timer armed.
    for (int v = 0; v < 2; v++) begin
      do_reset();
      drive(1, 0, 0, 0); drive(1, 0, 0, 0);
      drive(0, 1, 0, 0);
      drive(0, 0, 1, (v == 1) ? 5 : 30);
      idle(3);
      check("t6_pre_blocked", blocked_o, v);
      reset_p = 1;
      @(negedge clk);
      reset_p = 0;
      check("t6_level", level_o, 0);
      check("t6_step", timer_step_o, 0);
      check("t6_remain", remain_s, 0);
      check("t6_blocked", blocked_o, 0);
      check("t6_pwm", motor_pwm_o, 0);
      check("t6_led", level_led, 0);
    end

    // Randomised traffic against the model.
    do_reset();
    repeat (20000) begin
      speed_btn  = ($urandom_range(0, 15) == 0);
      timer_btn  = ($urandom_range(0, 63) == 0);
      dist_valid = ($urandom_range(0, 3) == 0);
      distance   = DIST_W'($urandom_range(0, 30));
      reset_p    = ($urandom_range(0, 1999) == 0);
      @(negedge clk);
    end
    speed_btn = 0; timer_btn = 0; dist_valid = 0; reset_p = 0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
